dvp_capture_ctrl: RTL and testbench
===================================

// Module: dvp_capture_ctrl
// PURPOSE
//  Frame-level sequencer between DVP_Capture and the frame-buffer writer.
//  - Arms on a Start command and skips SkipFrames sensor frames for settling.
//  - Passes whole frames only, in single-shot or continuous mode; continuous mode can decimate.
//  - Counts captured frames and reports start/done/busy status to the host register block.
// PARAMETERS
//  IMG_W  16  expected valid pixels per line (used by size check)
//  IMG_H  12  expected lines per frame (used by size check)
// PORTS
//  Clk         in   1   pixel clock (same domain as DVP_Capture PCLK)
//  Rst         in   1   synchronous reset, active-high
//  Start       in   1   1-cycle pulse: arm capture (accepted only in IDLE)
//  Stop        in   1   1-cycle pulse: stop after current frame
//  Mode        in   1   0 = single frame, 1 = continuous
//  SkipFrames  in   8   frames discarded after Start (sampled at Start)
//  Decim       in   4   continuous mode: frames discarded between captures (sampled at Start)
//  InValid     in   1   DVP_Capture DataValid
//  InPixel     in   16  DVP_Capture DataPixel
//  InHs        in   1   DVP_Capture DataHs (high during active line)
//  InVs        in   1   DVP_Capture DataVs (high during vertical blanking)
//  OutValid    out  1   gated pixel valid
//  OutPixel    out  16  registered pixel
//  OutHs       out  1   gated line-active flag
//  FrameStart  out  1   1-cycle pulse at the start of a captured frame
//  FrameDone   out  1   1-cycle pulse at the end of a captured frame
//  Busy        out  1   high whenever the state is not IDLE
//  FrameCnt    out  16  captured-frame count
//  SizeErr     out  1   sticky frame-size error
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0. InVs_d <= 0, so no falling edge is seen until InVs has been seen high.
//  - Edges: vs_fall = ~InVs & InVs_d; vs_rise = InVs & ~InVs_d.
//  - States: IDLE, ARM, CAPTURE.
//  - IDLE:
//      Start & ~Stop -> ARM. skip_cnt <= SkipFrames; Decim is latched; FrameCnt <= 0; SizeErr <= 0.
//      Start & Stop in the same cycle -> remain IDLE.
//  - ARM:
//      Stop -> IDLE.
//      vs_fall with skip_cnt != 0 -> skip_cnt--.
//      vs_fall with skip_cnt == 0 -> CAPTURE; FrameStart pulses one cycle later.
//      A frame already in progress when Start is accepted is never captured.
//      Start is ignored.
//  - CAPTURE:
//      OutValid/OutHs/OutPixel = InValid/InHs/InPixel delayed by 1 register. Latency is 1 Clk.
//      On vs_rise: FrameDone pulses next cycle; FrameCnt++ (wraps 0xFFFF -> 0).
//        Mode 0, or Stop pending -> IDLE.
//        Mode 1 -> ARM with skip_cnt <= latched Decim.
//      Stop during CAPTURE sets stop_pend. The frame always completes; frames are never truncated.
//      stop_pend clears on entry to IDLE.
//  - Outside CAPTURE: OutValid = 0 and OutHs = 0. OutPixel holds its last value.
//  - Gating covers registered outputs: the pixel accepted in the cycle of vs_rise is still forwarded;
//    none is forwarded after.
//  - Mode is sampled at each vs_rise in CAPTURE.
//  - A vs_fall in the same cycle as Start is not counted.
// CONFIGURATION
//  - Macro FRAME_SIZE_CHECK_EN defined:
//      Count InValid per line; compare at InHs falling edge against IMG_W.
//      Count lines per frame; compare at vs_rise against IMG_H.
//      Any mismatch sets SizeErr; it stays set until the next accepted Start.
//      FrameDone still pulses on a size error.
//  - Macro not defined: the counters are absent and SizeErr is tied to 0.
// STRUCTURE
//  - Package dvp_capture_ctrl_pkg: state encoding (ST_IDLE/ST_ARM/ST_CAPTURE), MODE_SINGLE/MODE_CONT,
//    count widths.
//  - Sub-module dvp_frame_size_checker (pixel and line counters plus compare), instantiated
//    under FRAME_SIZE_CHECK_EN.
// TESTING  (16x12 frames, 80 ns Clk, Vsync/Href timing as in the DVP_Capture bench)
//  1. Mode=0, SkipFrames=2, Start mid-frame.
//     -> Partial frame plus 2 full frames are dropped. Exactly 192 OutValid in frame 3.
//     -> FrameStart and FrameDone each pulse once; FrameCnt=1; Busy falls after FrameDone.
//  2. Mode=1, SkipFrames=0, Decim=1, 8 frames.
//     -> Frames 1,3,5,7 are passed; FrameCnt=4. OutPixel equals InPixel delayed 1 Clk.
//  3. Mode=1, Stop asserted at pixel 100 of the 2nd captured frame.
//     -> That frame completes with 192 pixels. Then IDLE; no further OutValid.
//  4. Start and Stop in the same cycle in IDLE -> Busy stays 0.
//     Stop during ARM -> IDLE with no FrameStart.
//  5. Rst pulsed mid-CAPTURE -> all outputs 0 the next cycle; state IDLE; no FrameDone.
//  6. FRAME_SIZE_CHECK_EN, one line of 15 pixels -> SizeErr=1 after that frame's FrameDone;
//     it clears on the next Start. Without the macro, SizeErr=0 throughout.

Source files
------------

// File: rtl/dvp_capture_ctrl_pkg.sv
// Package: dvp_capture_ctrl_pkg
// Purpose: shared constants for the DVP frame-level capture sequencer.
//   - FSM state encoding (ST_IDLE / ST_ARM / ST_CAPTURE)
//   - capture mode encoding (MODE_SINGLE / MODE_CONT)
//   - counter and data widths
//   - keep_running(): decides whether a finished capture re-arms
package dvp_capture_ctrl_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_CONT   = 1'b1;

  localparam int SKIP_W   = 8;   // SkipFrames / skip counter width
  localparam int DECIM_W  = 4;   // Decim width
  localparam int FCNT_W   = 16;  // captured-frame counter width
  localparam int PIX_W    = 16;  // pixel data width
  localparam int SZ_CNT_W = 12;  // size-checker pixel/line counter width

  // A finished frame re-arms only in continuous mode with no stop requested.
  function automatic logic keep_running(input logic mode, input logic stop);
    if (stop || (mode == MODE_SINGLE)) begin
      return 1'b0;
    end
    return (mode == MODE_CONT);
  endfunction

endpackage

// File: rtl/dvp_frame_size_checker.sv
// Module: dvp_frame_size_checker
// Purpose: counts valid pixels per line and lines per frame while a frame
//   is being captured and raises a sticky error on any size mismatch.
// Ports:
//   clk       in  1  pixel clock
//   srst      in  1  synchronous reset, active-high
//   clear     in  1  clears the sticky error (accepted Start)
//   en        in  1  counting enabled (capture in progress); counters cleared when low
//   in_valid  in  1  pixel valid
//   in_hs     in  1  line active flag
//   vs_rise   in  1  end-of-frame strobe (vertical blanking starts)
//   size_err  out 1  sticky size error
module dvp_frame_size_checker
  import dvp_capture_ctrl_pkg::*;
#(
  parameter int IMG_W = 16,
  parameter int IMG_H = 12
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic en,
  input  logic in_valid,
  input  logic in_hs,
  input  logic vs_rise,
  output logic size_err
);

  logic                hs_d_reg;
  logic [SZ_CNT_W-1:0] pix_cnt_reg;
  logic [SZ_CNT_W-1:0] line_cnt_reg;
  logic                err_reg;
  logic                hs_fall;

  assign hs_fall  = hs_d_reg & ~in_hs;
  assign size_err = err_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      hs_d_reg     <= 1'b0;
      pix_cnt_reg  <= '0;
      line_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      hs_d_reg <= in_hs;
      if (!en) begin
        pix_cnt_reg  <= '0;
        line_cnt_reg <= '0;
      end else begin
        if (hs_fall) begin
          if (pix_cnt_reg != SZ_CNT_W'(IMG_W)) begin
            err_reg <= 1'b1;
          end
          pix_cnt_reg  <= '0;
          line_cnt_reg <= line_cnt_reg + SZ_CNT_W'(1);
        end else if (in_valid && in_hs) begin
          pix_cnt_reg <= pix_cnt_reg + SZ_CNT_W'(1);
        end
        if (vs_rise) begin
          if (line_cnt_reg != SZ_CNT_W'(IMG_H)) begin
            err_reg <= 1'b1;
          end
          line_cnt_reg <= '0;
          pix_cnt_reg  <= '0;
        end
      end
      // Clearing wins over a mismatch seen in the same cycle.
      if (clear) begin
        err_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dvp_capture_ctrl.sv
// Module: dvp_capture_ctrl
// Purpose: frame-level sequencer between DVP_Capture and the frame-buffer
//   writer. Arms on Start, skips SkipFrames settling frames, then forwards
//   whole frames (single-shot or continuous with decimation), counts
//   captured frames and reports status.
// Optional feature: define FRAME_SIZE_CHECK_EN to build the frame-size
//   checker; otherwise SizeErr is tied to 0.
// Ports:
//   Clk, Rst                 clock, synchronous active-high reset
//   Start, Stop              1-cycle command pulses
//   Mode                     0 single frame, 1 continuous
//   SkipFrames[7:0]          settling frames dropped after Start
//   Decim[3:0]               frames dropped between continuous captures
//   InValid/InPixel/InHs/InVs  DVP_Capture stream (InVs high in blanking)
//   OutValid/OutPixel/OutHs  gated stream, 1 Clk latency
//   FrameStart, FrameDone    1-cycle frame pulses
//   Busy                     state is not IDLE
//   FrameCnt[15:0]           captured-frame count
//   SizeErr                  sticky size error
module dvp_capture_ctrl
  import dvp_capture_ctrl_pkg::*;
#(
  parameter int IMG_W = 16,
  parameter int IMG_H = 12
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic              Stop,
  input  logic              Mode,
  input  logic [SKIP_W-1:0] SkipFrames,
  input  logic [DECIM_W-1:0] Decim,
  input  logic              InValid,
  input  logic [PIX_W-1:0]  InPixel,
  input  logic              InHs,
  input  logic              InVs,
  output logic              OutValid,
  output logic [PIX_W-1:0]  OutPixel,
  output logic              OutHs,
  output logic              FrameStart,
  output logic              FrameDone,
  output logic              Busy,
  output logic [FCNT_W-1:0] FrameCnt,
  output logic              SizeErr
);

  logic [1:0]         state_reg;
  logic               vs_d_reg;
  logic [SKIP_W-1:0]  skip_cnt_reg;
  logic [DECIM_W-1:0] decim_reg;
  logic               stop_pend_reg;
  logic               out_valid_reg;
  logic               out_hs_reg;
  logic [PIX_W-1:0]   out_pixel_reg;
  logic               frame_start_reg;
  logic               frame_done_reg;
  logic [FCNT_W-1:0]  frame_cnt_reg;
  logic               vs_fall;
  logic               vs_rise;
  logic               start_accept;

  // vs_d_reg resets low, so no falling edge appears before InVs was seen high.
  assign vs_fall      = ~InVs & vs_d_reg;
  assign vs_rise      = InVs & ~vs_d_reg;
  assign start_accept = (state_reg == ST_IDLE) && Start && !Stop;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg       <= ST_IDLE;
      vs_d_reg        <= 1'b0;
      skip_cnt_reg    <= '0;
      decim_reg       <= '0;
      stop_pend_reg   <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_hs_reg      <= 1'b0;
      out_pixel_reg   <= '0;
      frame_start_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_cnt_reg   <= '0;
    end else begin
      vs_d_reg        <= InVs;
      frame_start_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_hs_reg      <= 1'b0;

      // Gating uses the current state, so the pixel in the vs_rise cycle
      // is still forwarded while nothing after it is.
      if (state_reg == ST_CAPTURE) begin
        out_valid_reg <= InValid;
        out_hs_reg    <= InHs;
        out_pixel_reg <= InPixel;
      end

      case (state_reg)
        ST_IDLE: begin
          if (start_accept) begin
            state_reg     <= ST_ARM;
            skip_cnt_reg  <= SkipFrames;
            decim_reg     <= Decim;
            frame_cnt_reg <= '0;
          end
        end
        ST_ARM: begin
          // Arming waits for a vs_fall, so a frame already running is skipped.
          if (Stop) begin
            state_reg <= ST_IDLE;
          end else if (vs_fall) begin
            if (skip_cnt_reg != '0) begin
              skip_cnt_reg <= skip_cnt_reg - SKIP_W'(1);
            end else begin
              state_reg       <= ST_CAPTURE;
              frame_start_reg <= 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
          if (Stop) begin
            stop_pend_reg <= 1'b1;
          end
          if (vs_rise) begin
            frame_done_reg <= 1'b1;
            frame_cnt_reg  <= frame_cnt_reg + FCNT_W'(1);
            if (keep_running(Mode, stop_pend_reg | Stop)) begin
              state_reg    <= ST_ARM;
              skip_cnt_reg <= SKIP_W'(decim_reg);
            end else begin
              state_reg     <= ST_IDLE;
              stop_pend_reg <= 1'b0;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign OutValid   = out_valid_reg;
  assign OutHs      = out_hs_reg;
  assign OutPixel   = out_pixel_reg;
  assign FrameStart = frame_start_reg;
  assign FrameDone  = frame_done_reg;
  assign FrameCnt   = frame_cnt_reg;
  assign Busy       = (state_reg != ST_IDLE);

`ifdef FRAME_SIZE_CHECK_EN
  dvp_frame_size_checker #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_size_checker (
    .clk      (Clk),
    .srst     (Rst),
    .clear    (start_accept),
    .en       (state_reg == ST_CAPTURE),
    .in_valid (InValid),
    .in_hs    (InHs),
    .vs_rise  (vs_rise),
    .size_err (SizeErr)
  );
`else
  assign SizeErr = 1'b0;
`endif

endmodule

// File: tb/tb_dvp_capture_ctrl.sv
// Testbench: tb_dvp_capture_ctrl
// Drives 16x12 DVP frames into dvp_capture_ctrl. Every pixel that should be
// forwarded is pushed with its drive cycle into a scoreboard queue; the
// monitor pops on each OutValid and checks value and 1-cycle latency.
// Frame/status counts are checked at the end of each scenario.
module tb_dvp_capture_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic        Stop;
  logic        Mode;
  logic [7:0]  SkipFrames;
  logic [3:0]  Decim;
  logic        InValid;
  logic [15:0] InPixel;
  logic        InHs;
  logic        InVs;
  logic        OutValid;
  logic [15:0] OutPixel;
  logic        OutHs;
  logic        FrameStart;
  logic        FrameDone;
  logic        Busy;
  logic [15:0] FrameCnt;
  logic        SizeErr;

`ifdef FRAME_SIZE_CHECK_EN
  localparam logic EXP_SZ = 1'b1;
`else
  localparam logic EXP_SZ = 1'b0;
`endif

  always #40 Clk = ~Clk;

  dvp_capture_ctrl #(.IMG_W(16), .IMG_H(12)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Start      (Start),
    .Stop       (Stop),
    .Mode       (Mode),
    .SkipFrames (SkipFrames),
    .Decim      (Decim),
    .InValid    (InValid),
    .InPixel    (InPixel),
    .InHs       (InHs),
    .InVs       (InVs),
    .OutValid   (OutValid),
    .OutPixel   (OutPixel),
    .OutHs      (OutHs),
    .FrameStart (FrameStart),
    .FrameDone  (FrameDone),
    .Busy       (Busy),
    .FrameCnt   (FrameCnt),
    .SizeErr    (SizeErr)
  );

  typedef struct {
    logic [15:0] pix;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   fs_cnt    = 0;
  int   fd_cnt    = 0;
  int   pix_cnt   = 0;
  int   frame_no  = 0;
  bit   rst_pulse = 1'b0;
  bit   mon_en    = 1'b0;
  int   fs0, fd0, px0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: pixel scoreboard plus frame pulse counting.
  initial begin
    forever begin
      exp_t e;
      @(negedge Clk);
      if (mon_en) begin
        if (FrameStart) fs_cnt++;
        if (FrameDone) fd_cnt++;
        if (OutValid) begin
          pix_cnt++;
          if (sb.size() == 0) begin
            check_eq("extra_pix", OutValid, 0);
          end else begin
            e = sb.pop_front();
            check_eq("pix", OutPixel, e.pix);
            check_eq("lat", cyc, e.cyc + 1);
            check_eq("out_hs", OutHs, 1);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge Clk);
    Start = 1'b0;
    Stop  = 1'b0;
    if (rst_pulse) begin
      check_eq("rst_outs", {OutValid, OutHs, OutPixel, FrameStart, FrameDone,
                            Busy, FrameCnt, SizeErr}, 0);
      Rst       = 1'b0;
      rst_pulse = 1'b0;
    end
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      InVs = 1'b1; InHs = 1'b0; InValid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    tick();
    Start = 1'b1;
  endtask

  task automatic pulse_stop();
    tick();
    Stop = 1'b1;
  endtask

  // One frame: 6 blanking cycles, 3 porch cycles, 12 lines of 16 pixels
  // (short_line gets 15) with 4-cycle line gaps. Pulses are placed at a
  // given valid-pixel index; pixels are queued only when cap is set.
  task automatic send_frame(input bit cap, input int short_line, input int start_at,
                            input int stop_at, input int rst_at);
    int   idx;
    int   npix;
    bit   killed;
    exp_t e;
    idx    = 0;
    killed = 1'b0;
    blank(6);
    for (int i = 0; i < 3; i++) begin
      tick();
      InVs = 1'b0;
    end
    for (int ln = 0; ln < 12; ln++) begin
      npix = (ln == short_line) ? 15 : 16;
      for (int p = 0; p < npix; p++) begin
        tick();
        InHs    = 1'b1;
        InValid = 1'b1;
        InPixel = 16'($urandom);
        if (idx == start_at) Start = 1'b1;
        if (idx == stop_at) Stop = 1'b1;
        if (idx == rst_at) begin
          Rst       = 1'b1;
          rst_pulse = 1'b1;
          killed    = 1'b1;
        end
        if (cap && !killed) begin
          e.pix = InPixel;
          e.cyc = cyc;
          sb.push_back(e);
        end
        idx++;
      end
      for (int g = 0; g < 4; g++) begin
        tick();
        InHs    = 1'b0;
        InValid = 1'b0;
      end
    end
    frame_no++;
    $display("frame %0d sent cap=%0b pixels=%0d", frame_no, cap, idx);
  endtask

  task automatic snap();
    fs0 = fs_cnt;
    fd0 = fd_cnt;
    px0 = pix_cnt;
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; Stop = 1'b0; Mode = 1'b0;
    SkipFrames = 8'd0; Decim = 4'd0;
    InValid = 1'b0; InPixel = 16'd0; InHs = 1'b0; InVs = 1'b0;
    repeat (4) @(negedge Clk);
    check_eq("reset_outs", {OutValid, OutHs, OutPixel, FrameStart, FrameDone,
                            Busy, FrameCnt, SizeErr}, 0);
    Rst    = 1'b0;
    mon_en = 1'b1;

    // 1: single shot, skip 2, Start mid-frame -> 4th frame captured.
    Mode = 1'b0; SkipFrames = 8'd2;
    snap();
    send_frame(1'b0, -1, 50, -1, -1);
    send_frame(1'b0, -1, -1, -1, -1);
    send_frame(1'b0, -1, -1, -1, -1);
    send_frame(1'b1, -1, -1, -1, -1);
    blank(10);
    check_eq("t1_pix", pix_cnt - px0, 192);
    check_eq("t1_fs", fs_cnt - fs0, 1);
    check_eq("t1_fd", fd_cnt - fd0, 1);
    check_eq("t1_cnt", FrameCnt, 1);
    check_eq("t1_busy", Busy, 0);
    check_eq("t1_sizeerr", SizeErr, 0);
    check_eq("t1_q", sb.size(), 0);
    $display("test 1 done");

    // 2: continuous, decimate by 1 over 8 frames -> frames 1,3,5,7.
    Mode = 1'b1; SkipFrames = 8'd0; Decim = 4'd1;
    snap();
    blank(2);
    pulse_start();
    for (int f = 0; f < 8; f++) send_frame((f % 2) == 0, -1, -1, -1, -1);
    blank(10);
    check_eq("t2_pix", pix_cnt - px0, 768);
    check_eq("t2_fs", fs_cnt - fs0, 4);
    check_eq("t2_fd", fd_cnt - fd0, 4);
    check_eq("t2_cnt", FrameCnt, 4);
    check_eq("t2_busy_arm", Busy, 1);
    pulse_stop();
    tick();
    check_eq("t2_busy_stop", Busy, 0);
    check_eq("t2_q", sb.size(), 0);
    $display("test 2 done");

    // 3: continuous, Stop at pixel 100 of 2nd captured frame.
    Decim = 4'd0;
    snap();
    blank(2);
    pulse_start();
    send_frame(1'b1, -1, -1, -1, -1);
    send_frame(1'b1, -1, -1, 100, -1);
    send_frame(1'b0, -1, -1, -1, -1);
    blank(10);
    check_eq("t3_pix", pix_cnt - px0, 384);
    check_eq("t3_fd", fd_cnt - fd0, 2);
    check_eq("t3_cnt", FrameCnt, 2);
    check_eq("t3_busy", Busy, 0);
    check_eq("t3_q", sb.size(), 0);
    $display("test 3 done");

    // 4: Start+Stop together ignored; Stop during ARM returns to IDLE.
    Mode = 1'b0;
    tick();
    Start = 1'b1; Stop = 1'b1;
    tick();
    tick();
    check_eq("t4_startstop_busy", Busy, 0);
    SkipFrames = 8'd3;
    pulse_start();
    tick();
    check_eq("t4_arm_busy", Busy, 1);
    pulse_stop();
    tick();
    check_eq("t4_stop_busy", Busy, 0);
    snap();
    send_frame(1'b0, -1, -1, -1, -1);
    send_frame(1'b0, -1, -1, -1, -1);
    blank(5);
    check_eq("t4_fs", fs_cnt - fs0, 0);
    check_eq("t4_busy_end", Busy, 0);
    $display("test 4 done");

    // 5: reset pulsed mid-capture.
    SkipFrames = 8'd0;
    snap();
    blank(2);
    pulse_start();
    send_frame(1'b1, -1, -1, -1, 60);
    blank(10);
    check_eq("t5_fs", fs_cnt - fs0, 1);
    check_eq("t5_fd", fd_cnt - fd0, 0);
    check_eq("t5_pix", pix_cnt - px0, 60);
    check_eq("t5_cnt", FrameCnt, 0);
    check_eq("t5_busy", Busy, 0);
    check_eq("t5_q", sb.size(), 0);
    $display("test 5 done");

    // 6: frame with a 15-pixel line.
    snap();
    blank(2);
    pulse_start();
    send_frame(1'b1, 5, -1, -1, -1);
    blank(10);
    check_eq("t6_fd", fd_cnt - fd0, 1);
    check_eq("t6_cnt", FrameCnt, 1);
    check_eq("t6_sizeerr", SizeErr, EXP_SZ);
    check_eq("t6_q", sb.size(), 0);
    pulse_start();
    tick();
    check_eq("t6_sizeerr_clr", SizeErr, 0);
    check_eq("t6_busy", Busy, 1);
    pulse_stop();
    tick();
    check_eq("t6_busy_end", Busy, 0);
    $display("test 6 done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
